med_lcd_driver: RTL and testbench

// Downstream of the LCD register stage. Drives an HD44780-compatible character LCD in 4-bit mode.

---
 rtl/med_lcd_driver.sv | 241 ++++++++++++++++++++++++
 tb/tb_med_lcd_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/med_lcd_driver.sv
// HD44780 4-bit character LCD driver: power-on init, then each accepted log byte is shown as two hex chars.
// Optional LCD_CLEAR_ON_WRAP_EN: on line wrap, clear the display (0x01) instead of cursor-home (0x80).
module med_lcd_driver #(
    parameter int POWERUP_CYC = 1500,
    parameter int INIT_CYC    = 200,
    parameter int CMD_CYC     = 40,
    parameter int CLEAR_CYC   = 800,
    parameter int E_PULSE_CYC = 2,
    parameter int COLS        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);
    localparam int MAX_A = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int MAX_B = (INIT_CYC > CMD_CYC) ? INIT_CYC : CMD_CYC;
    localparam int MAX_C = (MAX_B > E_PULSE_CYC) ? MAX_B : E_PULSE_CYC;
    localparam int MAXW  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW    = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int COLW  = $clog2(COLS + 1);

    // Counters are loaded with N-1 and count down to zero, giving exactly N cycles.
    localparam logic [CW-1:0] C_PWR   = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] C_INIT  = CW'(INIT_CYC - 1);
    localparam logic [CW-1:0] C_CMD   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] C_CLEAR = CW'(CLEAR_CYC - 1);
    localparam logic [CW-1:0] C_EP    = CW'(E_PULSE_CYC - 1);

`ifdef LCD_CLEAR_ON_WRAP_EN
    localparam logic [7:0] WRAP_CMD = 8'h01;
`else
    localparam logic [7:0] WRAP_CMD = 8'h80;
`endif

    typedef enum logic [2:0] {S_PWRUP, S_WAKE, S_SET4, S_CFG, S_IDLE, S_HI, S_LO, S_WRAP} state_t;
    typedef enum logic [2:0] {P_HOLD, P_SETUP, P_PULSE, P_GAP, P_WAIT} phase_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] cfg_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    state_t          r_state, w_state;
    phase_t          r_ph, w_ph;
    logic [CW-1:0]   r_cnt, w_cnt, w_wlen;
    logic [1:0]      r_idx, w_idx;
    logic            r_lo, w_lo;
    logic            r_isbyte, w_isbyte;
    logic [7:0]      r_val, w_val;
    logic            r_rs, w_rs;
    logic [7:0]      r_data, w_data;
    logic [COLW-1:0] r_col, w_col;
    logic            r_done, w_done;
    logic            r_rdy, r_e;
    logic            w_fin, w_start, w_nbyte, w_nrs;
    logic [7:0]      w_nval;

    assign w_wlen = !r_isbyte ? C_INIT :
                    (!r_rs && r_val == 8'h01) ? C_CLEAR : C_CMD;

    always_comb begin
        w_state  = r_state;
        w_ph     = r_ph;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_lo     = r_lo;
        w_isbyte = r_isbyte;
        w_val    = r_val;
        w_rs     = r_rs;
        w_data   = r_data;
        w_col    = r_col;
        w_done   = r_done;
        w_fin    = 1'b0;
        w_start  = 1'b0;
        w_nbyte  = 1'b0;
        w_nrs    = 1'b0;
        w_nval   = 8'h00;

        // Nibble/byte engine: setup, E pulse, (gap + low nibble for bytes), wait.
        case (r_ph)
            P_SETUP: begin
                w_ph  = P_PULSE;
                w_cnt = C_EP;
            end
            P_PULSE: begin
                if (r_cnt == '0) begin
                    if (r_isbyte && !r_lo) begin
                        w_ph = P_GAP;
                    end else begin
                        w_ph  = P_WAIT;
                        w_cnt = w_wlen;
                    end
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            P_GAP: begin
                w_ph = P_SETUP;
                w_lo = 1'b1;
            end
            P_WAIT: begin
                if (r_cnt == '0) w_fin = 1'b1;
                else             w_cnt = r_cnt - 1'b1;
            end
            default: ;
        endcase

        if (w_fin) begin
            case (r_state)
                S_PWRUP: begin
                    w_state = S_WAKE;
                    w_idx   = 2'd0;
                    w_start = 1'b1;
                    w_nval  = 8'h03;
                end
                S_WAKE: begin
                    w_start = 1'b1;
                    if (r_idx == 2'd2) begin
                        w_state = S_SET4;
                        w_nval  = 8'h02;
                    end else begin
                        w_idx  = r_idx + 2'd1;
                        w_nval = 8'h03;
                    end
                end
                S_SET4: begin
                    w_state = S_CFG;
                    w_idx   = 2'd0;
                    w_start = 1'b1;
                    w_nbyte = 1'b1;
                    w_nval  = cfg_cmd(2'd0);
                end
                S_CFG: begin
                    if (r_idx == 2'd3) begin
                        w_state = S_IDLE;
                        w_ph    = P_HOLD;
                        w_done  = 1'b1;
                    end else begin
                        w_idx   = r_idx + 2'd1;
                        w_start = 1'b1;
                        w_nbyte = 1'b1;
                        w_nval  = cfg_cmd(r_idx + 2'd1);
                    end
                end
                S_HI: begin
                    w_col   = r_col + 1'b1;
                    w_state = S_LO;
                    w_start = 1'b1;
                    w_nbyte = 1'b1;
                    w_nrs   = 1'b1;
                    w_nval  = hex_char(r_data[3:0]);
                end
                S_LO: begin
                    w_col = r_col + 1'b1;
                    if (w_col == COLW'(COLS)) begin
                        w_state = S_WRAP;
                        w_start = 1'b1;
                        w_nbyte = 1'b1;
                        w_nval  = WRAP_CMD;
                    end else begin
                        w_state = S_IDLE;
                        w_ph    = P_HOLD;
                    end
                end
                S_WRAP: begin
                    w_col   = '0;
                    w_state = S_IDLE;
                    w_ph    = P_HOLD;
                end
                default: ;
            endcase
        end else if (r_state == S_IDLE && in_valid && r_rdy) begin
            w_data  = in_data;
            w_state = S_HI;
            w_start = 1'b1;
            w_nbyte = 1'b1;
            w_nrs   = 1'b1;
            w_nval  = hex_char(in_data[7:4]);
        end

        if (w_start) begin
            w_ph     = P_SETUP;
            w_lo     = 1'b0;
            w_isbyte = w_nbyte;
            w_val    = w_nval;
            w_rs     = w_nrs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_PWRUP;
            r_ph     <= P_WAIT;
            r_cnt    <= C_PWR;
            r_idx    <= '0;
            r_lo     <= 1'b0;
            r_isbyte <= 1'b0;
            r_val    <= '0;
            r_rs     <= 1'b0;
            r_data   <= '0;
            r_col    <= '0;
            r_done   <= 1'b0;
            r_rdy    <= 1'b0;
            r_e      <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ph     <= w_ph;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_lo     <= w_lo;
            r_isbyte <= w_isbyte;
            r_val    <= w_val;
            r_rs     <= w_rs;
            r_data   <= w_data;
            r_col    <= w_col;
            r_done   <= w_done;
            r_rdy    <= (w_state == S_IDLE);
            r_e      <= (w_ph == P_PULSE);
        end
    end

    assign in_ready  = r_rdy;
    assign init_done = r_done;
    assign lcd_rs    = r_rs;
    assign lcd_e     = r_e;
    assign lcd_d     = (r_isbyte && !r_lo) ? r_val[7:4] : r_val[3:0];
endmodule

// File: tb/tb_med_lcd_driver.sv
// Directed bench for med_lcd_driver: init sequence/timing, hex rendering, handshake, wrap and mid-byte reset.
module tb_med_lcd_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, init_done, lcd_rs, lcd_e;
    logic [3:0] lcd_d;

    med_lcd_driver dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .init_done(init_done), .lcd_rs(lcd_rs),
        .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

`ifdef LCD_CLEAR_ON_WRAP_EN
    localparam logic [7:0] WRAP_B = 8'h01;
    localparam int         WRAP_W = 802;
`else
    localparam logic [7:0] WRAP_B = 8'h80;
    localparam int         WRAP_W = 42;
`endif

    int vec = 0;
    int nfail = 0;
    int cyc = 0;
    int acc = 0;
    int acc_cyc[$];
    logic [4:0] rq[$];
    int rc[$];
    logic prev_e = 1'b0;
    int rdy_cyc = 0;
    int last_rise = 0;
    logic [3:0] init_seq [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    logic [7:0] set1 [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
    logic [7:0] set2 [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_e && !prev_e) begin
            rq.push_back({lcd_rs, lcd_d});
            rc.push_back(cyc);
        end
        prev_e <= lcd_e;
    end

    always @(posedge clk)
        if (rst_n && in_valid && in_ready) begin
            acc <= acc + 1;
            acc_cyc.push_back(cyc + 1);
        end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rise(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = 5'bx;
        if (rq.size() != 0) begin
            got = rq.pop_front();
            last_rise = rc.pop_front();
        end
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic chk_byte(input string tag, input logic rs, input logic [7:0] b);
        chk_rise(tag, {rs, b[7:4]});
        chk_rise(tag, {rs, b[3:0]});
    endtask

    task automatic chk_data(input string tag, input logic [7:0] d);
        chk_byte(tag, 1'b1, hexc(d[7:4]));
        chk_byte(tag, 1'b1, hexc(d[3:0]));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        rdy_cyc = cyc;
        chk(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        wait_ready("send_ready");
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_low_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic chk_init(input int acc0);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_done_cycle", cyc, 32'd3260);
        chk("no_accept_during_init", acc, acc0);
        chk("init_nibble_count", rq.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk_rise("init_nibble", {1'b0, init_seq[i]});
            if (i == 0) chk("first_rise_cycle", last_rise, 32'd1501);
        end
        chk("last_init_rise_cycle", last_rise, 32'd2458);
    endtask

    initial begin
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        chk("reset_e", 32'(lcd_e), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        chk("reset_done", 32'(init_done), 32'd0);
        chk("reset_rs_d", 32'({lcd_rs, lcd_d}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid held with 0x55 from reset
        chk_init(0);
        for (int n = 0; n < 300 && acc < 2; n++) @(negedge clk);
        in_valid = 1'b0;
        chk("held_accepts", acc, 32'd2);
        chk("accept0_cycle", acc_cyc[0], 32'd3261);
        chk("accept1_cycle", acc_cyc[1], 32'd3356);
        wait_ready("held_idle");
        chk("held_ready_cycle", rdy_cyc, 32'd3450);
        chk_data("held_55a", 8'h55);
        chk_data("held_55b", 8'h55);
        chk("held_no_extra_accept", acc, 32'd2);

        send(8'h4F);
        repeat (50) @(negedge clk);
        chk("ready_low_mid_byte", 32'(in_ready), 32'd0);
        wait_ready("idle_4F");
        chk_byte("char_4", 1'b1, 8'h34);
        chk_byte("char_F", 1'b1, 8'h46);
        chk("ready_after_cmd_wait", rdy_cyc - last_rise, 32'd42);

        send(8'h00); wait_ready("idle_00");
        send(8'h9A); wait_ready("idle_9A");
        send(8'hFF); wait_ready("idle_FF");
        chk_byte("char_00h", 1'b1, 8'h30);
        chk_byte("char_00l", 1'b1, 8'h30);
        chk_byte("char_9", 1'b1, 8'h39);
        chk_byte("char_A", 1'b1, 8'h41);
        chk_byte("char_FFh", 1'b1, 8'h46);
        chk_byte("char_FFl", 1'b1, 8'h46);

        // reset while lcd_e is high mid-byte
        send(8'h12);
        for (int n = 0; n < 200 && lcd_e !== 1'b1; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_e", 32'(lcd_e), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        chk("rst_mid_done", 32'(init_done), 32'd0);
        repeat (2) @(negedge clk);
        rq.delete();
        rc.delete();
        rst_n = 1'b1;
        chk_init(acc);

        // two full lines; each ends with one wrap command
        for (int i = 0; i < 8; i++) begin
            send(set1[i]);
            wait_ready("idle_set1");
        end
        for (int i = 0; i < 8; i++) chk_data("line1", set1[i]);
        chk_byte("wrap1", 1'b0, WRAP_B);
        chk("wrap1_wait", rdy_cyc - last_rise, WRAP_W);
        for (int i = 0; i < 8; i++) begin
            send(set2[i]);
            wait_ready("idle_set2");
        end
        for (int i = 0; i < 8; i++) chk_data("line2", set2[i]);
        chk_byte("wrap2", 1'b0, WRAP_B);
        chk("no_extra_rises", rq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, nfail);
        $finish;
    end
endmodule
